// File: rtl/tlp_trace_capture_if.sv
// AXI4-Lite register-port bundle for the TLP trace buffer.
// slave:  the trace buffer (accepts aw/w/ar, returns b/r).
// master: the debug host driving register accesses.
interface tlp_trace_capture_if;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [31:0] s_axi_wdata;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_araddr;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;

    modport slave (
        input  s_axi_awvalid, s_axi_awaddr, s_axi_wvalid, s_axi_wdata, s_axi_bready,
        input  s_axi_arvalid, s_axi_araddr, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
        output s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp
    );

    modport master (
        output s_axi_awvalid, s_axi_awaddr, s_axi_wvalid, s_axi_wdata, s_axi_bready,
        output s_axi_arvalid, s_axi_araddr, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
        input  s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp
    );
endinterface

// File: rtl/tlp_trace_capture.sv
// Multi-channel TLP trace buffer. Records accepted Avalon-ST beats from NCH
// stream taps into per-channel circular / stop-on-full buffers; control,
// status and oldest-first readback through an AXI4-Lite slave.
// Ports:
//   trn_clk, trn_rst      : sole clock, synchronous active-high reset
//   st_valid/ready/sop/eop: per-channel stream tap (observed only)
//   st_be, st_data        : channel c at [c*BEW +: BEW] / [c*DW +: DW]
//   axi                   : AXI4-Lite register port (slave modport)
module tlp_trace_capture #(
    parameter int unsigned NCH        = 2,
    parameter int unsigned DW         = 64,
    parameter int unsigned DEPTH_LOG2 = 9,
    localparam int unsigned BEW       = DW / 8
) (
    input  logic               trn_clk,
    input  logic               trn_rst,
    input  logic [NCH-1:0]     st_valid,
    input  logic [NCH-1:0]     st_ready,
    input  logic [NCH-1:0]     st_sop,
    input  logic [NCH-1:0]     st_eop,
    input  logic [NCH*BEW-1:0] st_be,
    input  logic [NCH*DW-1:0]  st_data,
    tlp_trace_capture_if.slave axi
);

    localparam int unsigned DL    = DEPTH_LOG2;
    localparam int unsigned DEPTH = 32'd1 << DL;
    localparam int unsigned CW    = DL + 1;
    localparam int unsigned EW    = BEW + 2 + DW;
    localparam int unsigned NW    = DW / 32;
    localparam int unsigned CHW   = (NCH > 1) ? $clog2(NCH) : 1;

    // Control registers
    logic        armed;
    logic        stop_on_full;
    logic        start_on_sop;
    logic [18:0] rd_sel;

    // Per-channel capture state
    logic [NCH-1:0][DL-1:0] wptr;
    logic [NCH-1:0][CW-1:0] cnt;
    logic [NCH-1:0]         sop_seen;
    logic [NCH-1:0]         full;
    logic [NCH-1:0]         beat;
    logic [NCH-1:0]         capturing;
    logic [NCH-1:0]         store;

    // Register-write decode
    logic       wr_fire;
    logic [5:0] wr_word;
    logic       ctrl_wr;
    logic       sel_wr;
    logic       clear;

    // Readback selection and read pipeline
    logic [2:0]    sel_ch;
    logic [15:0]   sel_idx;
    logic          sel_ok;
    logic [CHW-1:0] sel_c;
    logic [CHW-1:0] sel_c_q;
    logic [CW-1:0] sel_cnt;
    logic [DL-1:0] rd_phys;
    logic          sel_hit;
    logic          hit_q;
    logic [EW-1:0] rd_q [NCH];
    logic [EW-1:0] sel_entry;
    logic          ar_fire;
    logic          rd_pend;
    logic [5:0]    rd_word;
    logic [31:0]   rd_mux;
    logic [31:0]   status;
    logic [BEW+7:0] sideband;

    logic unused_ok;
    assign unused_ok = &{1'b0, axi.s_axi_awaddr[31:8], axi.s_axi_awaddr[1:0],
                         axi.s_axi_araddr[31:8], axi.s_axi_araddr[1:0],
                         axi.s_axi_wdata[31:19]};

    assign axi.s_axi_bresp = 2'b00;
    assign axi.s_axi_rresp = 2'b00;

    assign wr_fire = axi.s_axi_awready && axi.s_axi_awvalid && axi.s_axi_wvalid;
    assign wr_word = axi.s_axi_awaddr[7:2];
    assign ctrl_wr = wr_fire && (wr_word == 6'h00);
    assign sel_wr  = wr_fire && (wr_word == 6'h02);
    assign clear   = ctrl_wr && axi.s_axi_wdata[0];
    assign ar_fire = axi.s_axi_arready && axi.s_axi_arvalid;

    // Capture qualification per channel; a same-cycle clear drops the beat
    always_comb begin
        beat      = st_valid & st_ready;
        capturing = '0;
        store     = '0;
        for (int c = 0; c < NCH; c++) begin
            full[c]      = (cnt[c] == CW'(DEPTH));
            capturing[c] = armed && (!start_on_sop || sop_seen[c])
                           && !(stop_on_full && full[c]);
            store[c]     = beat[c] && armed && !clear
                           && !(stop_on_full && full[c])
                           && (!start_on_sop || sop_seen[c] || st_sop[c]);
        end
    end

    // Write-address/data handshake and write response
    always_ff @(posedge trn_clk) begin
        if (trn_rst) begin
            axi.s_axi_awready <= 1'b0;
            axi.s_axi_wready  <= 1'b0;
            axi.s_axi_bvalid  <= 1'b0;
        end else begin
            axi.s_axi_awready <= axi.s_axi_awvalid && axi.s_axi_wvalid
                                 && !axi.s_axi_bvalid && !axi.s_axi_awready;
            axi.s_axi_wready  <= axi.s_axi_awvalid && axi.s_axi_wvalid
                                 && !axi.s_axi_bvalid && !axi.s_axi_awready;
            if (wr_fire) begin
                axi.s_axi_bvalid <= 1'b1;
            end else if (axi.s_axi_bvalid && axi.s_axi_bready) begin
                axi.s_axi_bvalid <= 1'b0;
            end
        end
    end

    // CTRL and RD_SEL registers (clear bit is a pulse, not stored)
    always_ff @(posedge trn_clk) begin
        if (trn_rst) begin
            armed        <= 1'b0;
            stop_on_full <= 1'b0;
            start_on_sop <= 1'b0;
            rd_sel       <= '0;
        end else begin
            if (ctrl_wr) begin
                armed        <= axi.s_axi_wdata[1];
                stop_on_full <= axi.s_axi_wdata[2];
                start_on_sop <= axi.s_axi_wdata[3];
            end
            if (sel_wr) begin
                rd_sel <= axi.s_axi_wdata[18:0];
            end
        end
    end

    // Write pointer, occupancy and sop-seen tracking
    always_ff @(posedge trn_clk) begin
        if (trn_rst) begin
            wptr     <= '0;
            cnt      <= '0;
            sop_seen <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (clear) begin
                    wptr[c]     <= '0;
                    cnt[c]      <= '0;
                    sop_seen[c] <= 1'b0;
                end else begin
                    if (store[c]) begin
                        wptr[c] <= wptr[c] + DL'(1);
                        if (!full[c]) begin
                            cnt[c] <= cnt[c] + CW'(1);
                        end
                    end
                    if (!armed) begin
                        sop_seen[c] <= 1'b0;
                    end else if (start_on_sop && beat[c] && st_sop[c]) begin
                        sop_seen[c] <= 1'b1;
                    end
                end
            end
        end
    end

    // Oldest-first index translation for the selected channel
    assign sel_ch  = rd_sel[18:16];
    assign sel_idx = rd_sel[15:0];
    assign sel_ok  = (32'(sel_ch) < NCH);
    assign sel_c   = sel_ok ? CHW'(sel_ch) : '0;
    assign sel_cnt = cnt[sel_c];
    assign rd_phys = (full[sel_c] && !stop_on_full) ? (wptr[sel_c] + sel_idx[DL-1:0])
                                                    : sel_idx[DL-1:0];
    assign sel_hit = sel_ok && (sel_idx < 16'(sel_cnt));

    // Per-channel trace RAM: read-first, read port continuously follows RD_SEL
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [EW-1:0] mem [DEPTH];
        logic [EW-1:0] mem_q;

        always_ff @(posedge trn_clk) begin
            if (store[g]) begin
                mem[wptr[g]] <= {st_be[g*BEW +: BEW], st_eop[g], st_sop[g], st_data[g*DW +: DW]};
            end
            mem_q <= mem[rd_phys];
        end

        assign rd_q[g] = mem_q;
    end

    // Range check and channel captured alongside the RAM read
    always_ff @(posedge trn_clk) begin
        if (trn_rst) begin
            hit_q   <= 1'b0;
            sel_c_q <= '0;
        end else begin
            hit_q   <= sel_hit;
            sel_c_q <= sel_c;
        end
    end

    // Readback multiplexer
    always_comb begin
        rd_mux    = '0;
        status    = '0;
        sideband  = '0;
        sel_entry = rd_q[sel_c_q];
        status[0] = armed;
        for (int c = 0; c < NCH; c++) begin
            status[8 + c]  = full[c];
            status[16 + c] = capturing[c];
        end
        sideband[0]           = sel_entry[DW];
        sideband[1]           = sel_entry[DW + 1];
        sideband[BEW + 7 : 8] = sel_entry[DW + 2 +: BEW];
        case (rd_word)
            6'h00: rd_mux = {28'd0, start_on_sop, stop_on_full, armed, 1'b0};
            6'h01: rd_mux = status;
            6'h02: rd_mux = {13'd0, rd_sel};
            6'h03: rd_mux = sel_ok ? 32'(sel_cnt) : 32'd0;
            6'h04: rd_mux = hit_q ? 32'(sideband) : 32'd0;
            default: begin
                for (int k = 0; k < NW; k++) begin
                    if (hit_q && (rd_word == 6'(8 + k))) begin
                        rd_mux = sel_entry[k*32 +: 32];
                    end
                end
            end
        endcase
    end

    // Read channel: ar handshake, one lookup cycle, then held response
    always_ff @(posedge trn_clk) begin
        if (trn_rst) begin
            axi.s_axi_arready <= 1'b0;
            axi.s_axi_rvalid  <= 1'b0;
            axi.s_axi_rdata   <= '0;
            rd_pend           <= 1'b0;
            rd_word           <= '0;
        end else begin
            axi.s_axi_arready <= axi.s_axi_arvalid && !axi.s_axi_arready
                                 && !rd_pend && !axi.s_axi_rvalid;
            rd_pend <= ar_fire;
            if (ar_fire) begin
                rd_word <= axi.s_axi_araddr[7:2];
            end
            if (rd_pend) begin
                axi.s_axi_rvalid <= 1'b1;
                axi.s_axi_rdata  <= rd_mux;
            end else if (axi.s_axi_rvalid && axi.s_axi_rready) begin
                axi.s_axi_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tlp_trace_capture.sv
// Directed bench for tlp_trace_capture (NCH=2, DW=64, DEPTH_LOG2=4).
module tb_tlp_trace_capture;

    localparam int unsigned NCH = 2;
    localparam int unsigned DW  = 64;
    localparam int unsigned BEW = DW / 8;

    localparam logic [31:0] A_CTRL = 32'h00;
    localparam logic [31:0] A_STAT = 32'h04;
    localparam logic [31:0] A_SEL  = 32'h08;
    localparam logic [31:0] A_CNT  = 32'h0C;
    localparam logic [31:0] A_SB   = 32'h10;
    localparam logic [31:0] A_D0   = 32'h20;
    localparam logic [31:0] A_D1   = 32'h24;

    logic               trn_clk;
    logic               trn_rst;
    logic [NCH-1:0]     st_valid;
    logic [NCH-1:0]     st_ready;
    logic [NCH-1:0]     st_sop;
    logic [NCH-1:0]     st_eop;
    logic [NCH*BEW-1:0] st_be;
    logic [NCH*DW-1:0]  st_data;

    int checks;
    int fails;

    tlp_trace_capture_if axi ();

    tlp_trace_capture #(
        .NCH        (NCH),
        .DW         (DW),
        .DEPTH_LOG2 (4)
    ) dut (
        .trn_clk  (trn_clk),
        .trn_rst  (trn_rst),
        .st_valid (st_valid),
        .st_ready (st_ready),
        .st_sop   (st_sop),
        .st_eop   (st_eop),
        .st_be    (st_be),
        .st_data  (st_data),
        .axi      (axi)
    );

    initial trn_clk = 1'b0;
    always #5 trn_clk = ~trn_clk;

    task automatic cyc();
        @(posedge trn_clk);
        #1;
    endtask

    // Register write; optionally drives one beat on beat_ch in the handshake cycle
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input int beat_ch, input logic [63:0] beat_data);
        int n;
        n = 0;
        axi.s_axi_awaddr  = a;
        axi.s_axi_wdata   = d;
        axi.s_axi_awvalid = 1'b1;
        axi.s_axi_wvalid  = 1'b1;
        while (!axi.s_axi_awready && n < 20) begin cyc(); n++; end
        if (!axi.s_axi_awready) begin
            checks++; fails++;
            $display("FAIL wr_timeout: awready not seen for addr %h", a);
            axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0;
            return;
        end
        if (beat_ch >= 0) begin
            st_valid[beat_ch]            = 1'b1;
            st_ready[beat_ch]            = 1'b1;
            st_data[beat_ch*DW +: DW]    = beat_data;
            st_be[beat_ch*BEW +: BEW]    = '1;
        end
        cyc();
        axi.s_axi_awvalid = 1'b0;
        axi.s_axi_wvalid  = 1'b0;
        st_valid          = '0;
        n = 0;
        while (!axi.s_axi_bvalid && n < 20) begin cyc(); n++; end
        if (!axi.s_axi_bvalid) begin
            checks++; fails++;
            $display("FAIL wr_bresp_timeout: bvalid not seen for addr %h", a);
            return;
        end
        cyc();
    endtask

    // Register read; lat = cycles from ar handshake cycle to first rvalid cycle
    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output int lat);
        int n;
        n = 0; lat = -1; d = '0;
        axi.s_axi_araddr  = a;
        axi.s_axi_arvalid = 1'b1;
        while (!axi.s_axi_arready && n < 20) begin cyc(); n++; end
        if (!axi.s_axi_arready) begin
            checks++; fails++;
            $display("FAIL rd_timeout: arready not seen for addr %h", a);
            axi.s_axi_arvalid = 1'b0;
            return;
        end
        cyc();
        axi.s_axi_arvalid = 1'b0;
        lat = 1;
        while (!axi.s_axi_rvalid && lat < 20) begin cyc(); lat++; end
        if (!axi.s_axi_rvalid) begin
            checks++; fails++;
            $display("FAIL rd_rvalid_timeout: rvalid not seen for addr %h", a);
            return;
        end
        d = axi.s_axi_rdata;
        cyc();
    endtask

    task automatic send_beats(input int ch, input int n, input int first,
                              input logic sop_first, input logic eop_last);
        for (int i = 0; i < n; i++) begin
            st_valid[ch]           = 1'b1;
            st_ready[ch]           = 1'b1;
            st_data[ch*DW +: DW]   = 64'(first + i);
            st_be[ch*BEW +: BEW]   = '1;
            st_sop[ch]             = sop_first && (i == 0);
            st_eop[ch]             = eop_last && (i == n - 1);
            cyc();
        end
        st_valid = '0;
        st_sop   = '0;
        st_eop   = '0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int lat;
        trn_rst = 1'b1;
        repeat (3) cyc();
        checks++;
        if ({axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready, axi.s_axi_bvalid,
             axi.s_axi_rvalid, axi.s_axi_rdata, axi.s_axi_bresp, axi.s_axi_rresp} !== '0) begin
            fails++; $display("FAIL reset_outputs: rvalid=%b bvalid=%b rdata=%h expected all zero",
                              axi.s_axi_rvalid, axi.s_axi_bvalid, axi.s_axi_rdata);
        end
        trn_rst = 1'b0;
        cyc();
        axi_read(A_STAT, d, lat);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL reset_status: got %h exp %h", d, 32'h0); end
        checks++; if (lat !== 2) begin fails++; $display("FAIL read_latency: got %0d exp 2", lat); end
        axi_read(A_CNT, d, lat);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL reset_count: got %h exp %h", d, 32'h0); end
        axi_read(A_CTRL, d, lat);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL reset_ctrl: got %h exp %h", d, 32'h0); end
    endtask

    task automatic test_capture();
        logic [31:0] d;
        int lat;
        axi_write(A_CTRL, 32'h2, -1, '0);
        send_beats(0, 5, 1, 1'b1, 1'b1);
        // a valid beat with ready low is not an accepted beat
        st_valid[0] = 1'b1; st_ready[0] = 1'b0; st_data[0 +: DW] = 64'hDEAD;
        cyc();
        st_valid = '0; st_ready = '1;
        axi_write(A_SEL, 32'h0, -1, '0);
        axi_read(A_D0, d, lat);
        checks++; if (d !== 32'h1) begin fails++; $display("FAIL cap_idx0_data: got %h exp %h", d, 32'h1); end
        axi_read(A_D1, d, lat);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL cap_idx0_data_hi: got %h exp %h", d, 32'h0); end
        axi_read(A_SB, d, lat);
        checks++; if (d !== 32'hFF01) begin fails++; $display("FAIL cap_idx0_sideband: got %h exp %h", d, 32'hFF01); end
        axi_read(A_CNT, d, lat);
        checks++; if (d !== 32'd5) begin fails++; $display("FAIL cap_count: got %h exp %h", d, 32'd5); end
        axi_write(A_SEL, 32'h4, -1, '0);
        axi_read(A_SB, d, lat);
        checks++; if (d !== 32'hFF02) begin fails++; $display("FAIL cap_idx4_sideband: got %h exp %h", d, 32'hFF02); end
        axi_read(A_D0, d, lat);
        checks++; if (d !== 32'h5) begin fails++; $display("FAIL cap_idx4_data: got %h exp %h", d, 32'h5); end
        axi_write(A_SEL, 32'h5, -1, '0);
        axi_read(A_D0, d, lat);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL cap_idx_beyond_cnt: got %h exp %h", d, 32'h0); end
        axi_read(A_SEL, d, lat);
        checks++; if (d !== 32'h5) begin fails++; $display("FAIL rd_sel_readback: got %h exp %h", d, 32'h5); end
        axi_write(A_SEL, 32'h10000, -1, '0);
        axi_read(A_CNT, d, lat);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL cap_ch1_count: got %h exp %h", d, 32'h0); end
        axi_write(A_SEL, 32'h20000, -1, '0);
        axi_read(A_CNT, d, lat);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL bad_channel_count: got %h exp %h", d, 32'h0); end
        axi_read(A_STAT, d, lat);
        checks++; if (d !== 32'h00030001) begin fails++; $display("FAIL cap_status: got %h exp %h", d, 32'h00030001); end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        int lat;
        axi_write(A_CTRL, 32'h3, -1, '0);
        send_beats(1, 20, 1, 1'b0, 1'b0);
        axi_write(A_SEL, 32'h10000, -1, '0);
        axi_read(A_CNT, d, lat);
        checks++; if (d !== 32'd16) begin fails++; $display("FAIL wrap_count: got %h exp %h", d, 32'd16); end
        axi_read(A_STAT, d, lat);
        checks++; if (d !== 32'h00030201) begin fails++; $display("FAIL wrap_status: got %h exp %h", d, 32'h00030201); end
        axi_read(A_D0, d, lat);
        checks++; if (d !== 32'd5) begin fails++; $display("FAIL wrap_oldest: got %h exp %h", d, 32'd5); end
        axi_write(A_SEL, 32'h1000F, -1, '0);
        axi_read(A_D0, d, lat);
        checks++; if (d !== 32'd20) begin fails++; $display("FAIL wrap_newest: got %h exp %h", d, 32'd20); end
        axi_write(A_SEL, 32'h0, -1, '0);
        axi_read(A_CNT, d, lat);
        checks++; if (d !== 32'd0) begin fails++; $display("FAIL wrap_ch0_cleared: got %h exp %h", d, 32'd0); end
    endtask

    task automatic test_stop();
        logic [31:0] d;
        int lat;
        axi_write(A_CTRL, 32'h7, -1, '0);
        send_beats(1, 20, 1, 1'b0, 1'b0);
        axi_write(A_SEL, 32'h1000F, -1, '0);
        axi_read(A_CNT, d, lat);
        checks++; if (d !== 32'd16) begin fails++; $display("FAIL stop_count: got %h exp %h", d, 32'd16); end
        axi_read(A_D0, d, lat);
        checks++; if (d !== 32'd16) begin fails++; $display("FAIL stop_idx15: got %h exp %h", d, 32'd16); end
        axi_read(A_STAT, d, lat);
        checks++; if (d !== 32'h00010201) begin fails++; $display("FAIL stop_status: got %h exp %h", d, 32'h00010201); end
        send_beats(1, 4, 32'h99, 1'b0, 1'b0);
        axi_read(A_D0, d, lat);
        checks++; if (d !== 32'd16) begin fails++; $display("FAIL stop_idx15_after: got %h exp %h", d, 32'd16); end
        axi_write(A_SEL, 32'h10000, -1, '0);
        axi_read(A_D0, d, lat);
        checks++; if (d !== 32'd1) begin fails++; $display("FAIL stop_idx0_after: got %h exp %h", d, 32'd1); end
    endtask

    task automatic test_start_on_sop();
        logic [31:0] d;
        int lat;
        axi_write(A_CTRL, 32'hB, -1, '0);
        axi_read(A_STAT, d, lat);
        checks++; if (d !== 32'h00000001) begin fails++; $display("FAIL sos_status_wait: got %h exp %h", d, 32'h00000001); end
        send_beats(0, 3, 32'h11, 1'b0, 1'b0);
        send_beats(0, 1, 32'hAA, 1'b1, 1'b0);
        axi_write(A_SEL, 32'h0, -1, '0);
        axi_read(A_D0, d, lat);
        checks++; if (d !== 32'hAA) begin fails++; $display("FAIL sos_idx0: got %h exp %h", d, 32'hAA); end
        axi_read(A_CNT, d, lat);
        checks++; if (d !== 32'd1) begin fails++; $display("FAIL sos_count: got %h exp %h", d, 32'd1); end
        axi_read(A_STAT, d, lat);
        checks++; if (d !== 32'h00010001) begin fails++; $display("FAIL sos_status_run: got %h exp %h", d, 32'h00010001); end
    endtask

    task automatic test_clear_same_cycle();
        logic [31:0] d;
        int lat;
        axi_write(A_CTRL, 32'h2, -1, '0);
        send_beats(0, 2, 32'h50, 1'b0, 1'b0);
        axi_read(A_CNT, d, lat);
        checks++; if (d !== 32'd3) begin fails++; $display("FAIL clr_pre_count: got %h exp %h", d, 32'd3); end
        axi_write(A_CTRL, 32'h3, 0, 64'h66);
        axi_read(A_CNT, d, lat);
        checks++; if (d !== 32'd0) begin fails++; $display("FAIL clr_same_cycle_count: got %h exp %h", d, 32'd0); end
        send_beats(0, 1, 32'h77, 1'b0, 1'b0);
        axi_read(A_CNT, d, lat);
        checks++; if (d !== 32'd1) begin fails++; $display("FAIL clr_post_count: got %h exp %h", d, 32'd1); end
    endtask

    task automatic test_rready_hold();
        logic [31:0] d;
        int lat;
        axi.s_axi_rready = 1'b0;
        axi_read(A_D0, d, lat);
        checks++; if (d !== 32'h77) begin fails++; $display("FAIL hold_data: got %h exp %h", d, 32'h77); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (axi.s_axi_rvalid !== 1'b1 || axi.s_axi_rdata !== 32'h77) begin
                fails++; $display("FAIL hold_cycle%0d: rvalid=%b rdata=%h exp rvalid=1 rdata=%h",
                                  i, axi.s_axi_rvalid, axi.s_axi_rdata, 32'h77);
            end
            cyc();
        end
        axi.s_axi_rready = 1'b1;
        cyc();
        checks++; if (axi.s_axi_rvalid !== 1'b0) begin fails++; $display("FAIL hold_release: rvalid=%b exp 0", axi.s_axi_rvalid); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int lat;
        axi.s_axi_rready = 1'b0;
        axi_read(A_CNT, d, lat);
        trn_rst = 1'b1;
        cyc();
        checks++;
        if (axi.s_axi_rvalid !== 1'b0 || axi.s_axi_rdata !== 32'h0) begin
            fails++; $display("FAIL reset_mid_drop: rvalid=%b rdata=%h exp 0 0", axi.s_axi_rvalid, axi.s_axi_rdata);
        end
        trn_rst = 1'b0;
        axi.s_axi_rready = 1'b1;
        cyc();
        axi_read(A_CNT, d, lat);
        checks++; if (d !== 32'd0) begin fails++; $display("FAIL reset_mid_count: got %h exp %h", d, 32'd0); end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        trn_rst  = 1'b1;
        st_valid = '0;
        st_ready = '1;
        st_sop   = '0;
        st_eop   = '0;
        st_be    = '0;
        st_data  = '0;
        axi.s_axi_awvalid = 1'b0;
        axi.s_axi_awaddr  = '0;
        axi.s_axi_wvalid  = 1'b0;
        axi.s_axi_wdata   = '0;
        axi.s_axi_bready  = 1'b1;
        axi.s_axi_arvalid = 1'b0;
        axi.s_axi_araddr  = '0;
        axi.s_axi_rready  = 1'b1;

        test_reset();
        test_capture();
        test_wrap();
        test_stop();
        test_start_on_sop();
        test_clear_same_cycle();
        test_rready_hold();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
